// File: rtl/rggen_wishbone_timeout_guard.sv
// rggen_wishbone_timeout_guard: registered Wishbone stage that aborts unanswered slave transactions.
// A slave silent for TIMEOUT_CYCLES gets an error returned upstream so the register bus never hangs.
module rggen_wishbone_timeout_guard #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_adr,
    input  logic                     i_wb_we,
    input  logic [BUS_WIDTH-1:0]     i_wb_dat,
    input  logic [BUS_WIDTH/8-1:0]   i_wb_sel,
    output logic                     o_wb_ack,
    output logic                     o_wb_err,
    output logic                     o_wb_rty,
    output logic [BUS_WIDTH-1:0]     o_wb_dat,
    output logic                     o_slv_cyc,
    output logic                     o_slv_stb,
    input  logic                     i_slv_stall,
    output logic [ADDRESS_WIDTH-1:0] o_slv_adr,
    output logic                     o_slv_we,
    output logic [BUS_WIDTH-1:0]     o_slv_dat,
    output logic [BUS_WIDTH/8-1:0]   o_slv_sel,
    input  logic                     i_slv_ack,
    input  logic                     i_slv_err,
    input  logic                     i_slv_rty,
    input  logic [BUS_WIDTH-1:0]     i_slv_dat,
    output logic                     o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 cyc_nx, stb_nx, ack_nx, err_nx, rty_nx, to_nx;
    logic [BUS_WIDTH-1:0] rdat_nx;
    logic                 busy, capture, resp, last;

    assign o_wb_stall = state != IDLE;
    assign busy       = state == REQ || state == WAIT;
    assign capture    = state == IDLE && i_wb_cyc && i_wb_stb;
    // a stalled strobe has not been taken by the slave, so its response lines are not trusted yet
    assign resp       = (state == WAIT || (state == REQ && !i_slv_stall)) && (i_slv_ack || i_slv_err || i_slv_rty);
    assign last       = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_nx = state;
        cnt_nx   = busy ? cnt + 1'b1 : '0;
        cyc_nx   = 1'b0;
        stb_nx   = 1'b0;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        rty_nx   = 1'b0;
        to_nx    = 1'b0;
        rdat_nx  = '0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nx = REQ;
                    cyc_nx   = 1'b1;
                    stb_nx   = 1'b1;
                end
            end
            REQ, WAIT: begin
                if (!i_wb_cyc) begin
                    state_nx = IDLE;
                end else if (resp) begin
                    state_nx = RESP;
                    ack_nx   = i_slv_ack;
                    err_nx   = !i_slv_ack && i_slv_err;
                    rty_nx   = !i_slv_ack && !i_slv_err && i_slv_rty;
                    rdat_nx  = i_slv_ack ? i_slv_dat : '0;
                end else if (last) begin
                    state_nx = RESP;
                    err_nx   = 1'b1;
                    to_nx    = 1'b1;
                end else begin
                    cyc_nx   = 1'b1;
                    stb_nx   = state == REQ && i_slv_stall;
                    state_nx = stb_nx ? REQ : WAIT;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            o_slv_cyc <= 1'b0;
            o_slv_stb <= 1'b0;
            o_slv_adr <= '0;
            o_slv_we  <= 1'b0;
            o_slv_dat <= '0;
            o_slv_sel <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_rty  <= 1'b0;
            o_wb_dat  <= '0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            o_slv_cyc <= cyc_nx;
            o_slv_stb <= stb_nx;
            o_wb_ack  <= ack_nx;
            o_wb_err  <= err_nx;
            o_wb_rty  <= rty_nx;
            o_wb_dat  <= rdat_nx;
            o_timeout <= to_nx;
            if (capture) begin
                o_slv_adr <= i_wb_adr;
                o_slv_we  <= i_wb_we;
                o_slv_dat <= i_wb_dat;
                o_slv_sel <= i_wb_sel;
            end
        end
    end
endmodule

// File: tb/tb_rggen_wishbone_timeout_guard.sv
// tb_rggen_wishbone_timeout_guard: directed bench with a response scoreboard for the timeout guard.
module tb_rggen_wishbone_timeout_guard;
    logic        clk = 1'b0;
    logic        i_rst, i_wb_cyc, i_wb_stb, i_wb_we, o_wb_stall;
    logic [7:0]  i_wb_adr, o_slv_adr;
    logic [31:0] i_wb_dat, o_wb_dat, o_slv_dat, i_slv_dat;
    logic [3:0]  i_wb_sel, o_slv_sel;
    logic        o_wb_ack, o_wb_err, o_wb_rty, o_slv_cyc, o_slv_stb, o_slv_we, o_timeout;
    logic        i_slv_stall, i_slv_ack, i_slv_err, i_slv_rty;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        to;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cmp  = 0;
    int   errs = 0;
    int   n;

    always #5 clk = ~clk;

    rggen_wishbone_timeout_guard #(
        .ADDRESS_WIDTH(8),
        .BUS_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_wb_cyc(i_wb_cyc),
        .i_wb_stb(i_wb_stb),
        .o_wb_stall(o_wb_stall),
        .i_wb_adr(i_wb_adr),
        .i_wb_we(i_wb_we),
        .i_wb_dat(i_wb_dat),
        .i_wb_sel(i_wb_sel),
        .o_wb_ack(o_wb_ack),
        .o_wb_err(o_wb_err),
        .o_wb_rty(o_wb_rty),
        .o_wb_dat(o_wb_dat),
        .o_slv_cyc(o_slv_cyc),
        .o_slv_stb(o_slv_stb),
        .i_slv_stall(i_slv_stall),
        .o_slv_adr(o_slv_adr),
        .o_slv_we(o_slv_we),
        .o_slv_dat(o_slv_dat),
        .o_slv_sel(o_slv_sel),
        .i_slv_ack(i_slv_ack),
        .i_slv_err(i_slv_err),
        .i_slv_rty(i_slv_rty),
        .i_slv_dat(i_slv_dat),
        .o_timeout(o_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic push(input logic ack, input logic err, input logic rty, input logic to, input logic [31:0] dat);
        sb.push_back('{ack: ack, err: err, rty: rty, to: to, dat: dat});
    endtask

    task automatic slv_idle();
        i_slv_stall = 1'b0;
        i_slv_ack   = 1'b0;
        i_slv_err   = 1'b0;
        i_slv_rty   = 1'b0;
        i_slv_dat   = '0;
    endtask

    // returns one negedge after acceptance, with the slave strobe visible
    task automatic req(input logic we, input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        @(negedge clk);
        i_wb_stb = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int max);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            got = o_wb_ack | o_wb_err | o_wb_rty;
        end
        chk(tag, 64'(got), 64'd1);
        i_wb_cyc = 1'b0;
        slv_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({o_slv_cyc, o_slv_stb, o_slv_we, o_wb_ack, o_wb_err, o_wb_rty, o_timeout, o_wb_stall}), 64'd0);
        chk({tag, "_regs"}, 64'({o_slv_adr, o_slv_sel, o_wb_dat}), 64'd0);
        chk({tag, "_wdat"}, 64'(o_slv_dat), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!i_rst && (o_wb_ack || o_wb_err || o_wb_rty || o_timeout)) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'({o_wb_ack, o_wb_err, o_wb_rty, o_timeout}), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_bits", 64'({o_wb_ack, o_wb_err, o_wb_rty, o_timeout}), 64'({e.ack, e.err, e.rty, e.to}));
                chk("resp_dat", 64'(o_wb_dat), 64'(e.dat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we = 1'b0;
        i_wb_adr = '0;
        i_wb_dat = '0;
        i_wb_sel = '0;
        slv_idle();
        tick(2);
        chk_all_zero("reset");
        i_rst = 1'b0;

        req(1'b0, 8'h10, 32'h0, 4'hF);
        chk("rd_req", 64'({o_slv_cyc, o_slv_stb, o_slv_we, o_wb_stall}), 64'b1101);
        chk("rd_adr", 64'(o_slv_adr), 64'h10);
        tick(2);
        chk("rd_wait", 64'({o_slv_cyc, o_slv_stb}), 64'b10);
        i_slv_ack = 1'b1;
        i_slv_dat = 32'hA5A5_5A5A;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A);
        wait_resp("rd_resp", 1);

        i_slv_stall = 1'b1;
        req(1'b1, 8'h24, 32'h1234_5678, 4'hF);
        i_wb_adr = 8'hFF;
        i_wb_dat = 32'h0;
        i_wb_sel = 4'h0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_stb", 64'({o_slv_cyc, o_slv_stb, o_slv_we}), 64'b111);
            chk("wr_hold", 64'({o_slv_adr, o_slv_dat, o_slv_sel}), 64'({8'h24, 32'h1234_5678, 4'hF}));
            if (i == 3) i_slv_stall = 1'b0;
            else tick();
        end
        tick();
        chk("wr_wait", 64'({o_slv_cyc, o_slv_stb}), 64'b10);
        i_slv_ack = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        wait_resp("wr_resp", 1);

        push(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        req(1'b0, 8'h30, 32'h0, 4'hF);
        n = 0;
        while (o_slv_cyc === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 64'(n), 64'd16);
        chk("to_err_pulse", 64'({o_wb_err, o_timeout, o_wb_ack}), 64'b110);
        i_wb_cyc = 1'b0;
        tick();
        chk("to_clear", 64'({o_wb_err, o_timeout, o_wb_stall}), 64'd0);

        req(1'b0, 8'h40, 32'h0, 4'hF);
        tick(15);
        chk("last_cyc", 64'(o_slv_cyc), 64'd1);
        i_slv_ack = 1'b1;
        i_slv_dat = 32'hCAFE_F00D;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
        wait_resp("ack_at_last", 1);

        req(1'b0, 8'h50, 32'h0, 4'hF);
        i_slv_ack = 1'b1;
        i_slv_err = 1'b1;
        i_slv_dat = 32'h5555_AAAA;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
        wait_resp("ack_err", 1);

        req(1'b0, 8'h54, 32'h0, 4'hF);
        tick();
        i_slv_rty = 1'b1;
        i_slv_dat = 32'hDEAD_BEEF;
        push(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_resp("rty", 1);

        req(1'b0, 8'h58, 32'h0, 4'hF);
        i_slv_err = 1'b1;
        i_slv_rty = 1'b1;
        i_slv_dat = 32'h1111_2222;
        push(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_resp("err_rty", 1);

        req(1'b1, 8'h60, 32'h1, 4'h1);
        tick();
        chk("ab_wait", 64'({o_slv_cyc, o_slv_stb}), 64'b10);
        i_wb_cyc = 1'b0;
        tick();
        chk("ab_drop", 64'({o_slv_cyc, o_slv_stb, o_wb_stall, o_timeout}), 64'd0);
        i_slv_ack = 1'b1;
        tick();
        chk("ab_late", 64'({o_wb_ack, o_wb_err, o_wb_rty}), 64'd0);
        slv_idle();
        tick(2);

        req(1'b1, 8'h70, 32'h7777_7777, 4'hF);
        tick();
        i_rst = 1'b1;
        i_wb_cyc = 1'b0;
        tick();
        chk_all_zero("mid_rst");
        i_rst = 1'b0;
        i_slv_ack = 1'b1;
        tick();
        chk("rst_late", 64'({o_wb_ack, o_wb_err, o_wb_rty, o_wb_stall}), 64'd0);
        slv_idle();

        req(1'b0, 8'h74, 32'h0, 4'hF);
        i_slv_ack = 1'b1;
        i_slv_dat = 32'h0BAD_CAFE;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE);
        wait_resp("post_rst", 1);

        tick(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/rggen_wishbone_timeout_guard.md
Name: rggen_wishbone_timeout_guard

Overview:
- Wishbone stage that sits directly downstream of the RgGen Wishbone bridge, between the bridge master port and the external Wishbone slave.
- Registers each request, forwards it to the slave and registers the slave response back to the bridge.
- Aborts any transaction the slave has not answered within TIMEOUT_CYCLES and returns an error, so a dead slave cannot hang the register bus.

Parameters:
ADDRESS_WIDTH, 8, address width, both sides
BUS_WIDTH, 32, data width; select width is BUS_WIDTH/8
TIMEOUT_CYCLES, 16, maximum slave-side cycles per transaction; legal values are 2 and above; counter width is clog2(TIMEOUT_CYCLES)

Ports:
i_clk  in  1  clock; the block has this single clock domain
i_rst  in  1  synchronous reset, active-high
i_wb_cyc  in  1  upstream cycle
i_wb_stb  in  1  upstream strobe
o_wb_stall  out  1  upstream stall
i_wb_adr  in  ADDRESS_WIDTH  upstream address
i_wb_we  in  1  upstream write enable
i_wb_dat  in  BUS_WIDTH  upstream write data
i_wb_sel  in  BUS_WIDTH/8  upstream byte select
o_wb_ack  out  1  upstream acknowledge
o_wb_err  out  1  upstream error
o_wb_rty  out  1  upstream retry
o_wb_dat  out  BUS_WIDTH  upstream read data
o_slv_cyc  out  1  slave cycle
o_slv_stb  out  1  slave strobe
i_slv_stall  in  1  slave stall
o_slv_adr  out  ADDRESS_WIDTH  slave address (registered)
o_slv_we  out  1  slave write enable (registered)
o_slv_dat  out  BUS_WIDTH  slave write data (registered)
o_slv_sel  out  BUS_WIDTH/8  slave byte select (registered)
i_slv_ack  in  1  slave acknowledge
i_slv_err  in  1  slave error
i_slv_rty  in  1  slave retry
i_slv_dat  in  BUS_WIDTH  slave read data
o_timeout  out  1  one-cycle pulse when a transaction times out

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset (i_rst=1 at a clock edge, from any state):
  - State returns to IDLE.
  - All registered outputs go to 0: o_wb_ack/err/rty/dat, o_slv_cyc/stb/adr/we/dat/sel, o_timeout.
  - Timeout counter clears to 0.
  - A transaction in flight is dropped silently; no response is generated.
- o_wb_stall = (state != IDLE); this is the only combinational output.
- IDLE:
  - On i_wb_cyc && i_wb_stb: capture adr/we/dat/sel into the slave-side registers, clear the counter, go to REQ.
  - The request is accepted in the same cycle, since stall is low.
- REQ:
  - o_slv_cyc=1 and o_slv_stb=1.
  - When i_slv_stall=0, go to WAIT (o_slv_stb drops next cycle).
  - A response seen in REQ while i_slv_stall=0 is accepted as in WAIT.
- WAIT: o_slv_cyc=1, o_slv_stb=0.
- Response, in REQ or WAIT:
  - Trigger: any of i_slv_ack/err/rty is high.
  - o_slv_cyc and o_slv_stb drop, and the FSM goes to RESP.
  - Exactly one upstream response bit is registered high, with priority ack > err > rty.
  - o_wb_dat takes i_slv_dat on ack and 0 otherwise.
- RESP:
  - Response bits are high for exactly this one cycle, then clear.
  - Go to IDLE.
  - A new request can be accepted in the following IDLE cycle.
- Counter:
  - Starts at 0 in the first REQ cycle and increments each cycle in REQ/WAIT.
  - Timeout fires in a cycle where counter == TIMEOUT_CYCLES-1 and no slave response is present.
  - On timeout: drop slave cyc/stb, go to RESP with o_wb_err=1 and o_wb_dat=0, and pulse o_timeout in that RESP cycle.
- Upstream abort:
  - Trigger: i_wb_cyc=0 while in REQ/WAIT.
  - Slave cyc/stb drop next cycle and the FSM goes to IDLE with no upstream response and no o_timeout.
- Same-cycle priority: reset > upstream abort > slave response > timeout. A response arriving in the timeout cycle wins.
- Late slave responses arriving after abort, timeout or RESP are ignored.
- Latency:
  - Request accepted at cycle N; o_slv_stb=1 from N+1.
  - Slave response at cycle M; upstream response at M+1.
  - Zero-wait slave (ack at N+1): upstream ack at N+2.

Test Plan:
- Read, slave ack 2 cycles after stb, i_slv_dat=0xA5A5_5A5A -> o_wb_ack=1 for one cycle, o_wb_dat=0xA5A5_5A5A, o_wb_err=0, o_timeout=0.
- Write adr=0x24 dat=0x1234_5678 sel=0xF, slave stalls 3 cycles then ack -> o_slv_stb held 4 cycles with stable adr/dat/sel, then o_wb_ack one cycle.
- TIMEOUT_CYCLES=16, slave never responds -> o_slv_cyc drops after 16 slave cycles; o_wb_err=1 and o_timeout=1 in the same cycle; o_wb_dat=0.
- Slave ack exactly at counter=15 (TIMEOUT_CYCLES=16) -> o_wb_ack=1, o_wb_err=0, o_timeout=0.
- Slave asserts ack and err together -> o_wb_ack=1 only; rty alone -> o_wb_rty=1.
- i_wb_cyc drops in WAIT -> o_slv_cyc=0 next cycle, no upstream response. i_rst pulse mid-transaction -> all outputs 0, state IDLE, next request completes normally.
